// File: rtl/dcache_2way_ctrl.sv
// dcache_2way_ctrl
//   Controller for a 2-way set-associative data cache. The two way arrays sit
//   outside this block. They act on the negedge of clk and report
//   hit/valid/dirty/addr combinationally for the set addressed by way_addr.
//   This block handles one CPU load/store at a time:
//   lookup -> (victim writeback) -> refill -> install -> retry lookup -> done.
//   It keeps one LRU bit per set and counts first-lookup hits and misses.
//
// Ports
//   clk, rst                 posedge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/be CPU request, sampled in IDLE only
//   cpu_ready, cpu_rdata     one-cycle completion pulse and load data
//   cpu_busy                 high whenever the controller is not in IDLE
//   way_en/compare/read      way array controls
//   way_addr/wdata/be        latched request presented to both ways
//   way_line_in              line to install on refill
//   wayN_*                   status, resident address, word and line from way N
//   mem_req/we/addr/wline    line-wide memory request (registered)
//   mem_ack, mem_rline       memory completion pulse and refill data
//   hit_cnt, miss_cnt        performance counters, wrap modulo 2^CNT_W
module dcache_2way_ctrl #(
  parameter int LINE_W = 256,
  parameter int SETS   = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_busy,
  output logic [1:0]        way_en,
  output logic              way_compare,
  output logic              way_read,
  output logic [31:0]       way_addr,
  output logic [31:0]       way_wdata,
  output logic [3:0]        way_be,
  output logic [LINE_W-1:0] way_line_in,
  input  logic              way0_hit,
  input  logic              way0_dirty,
  input  logic              way0_valid,
  input  logic              way1_hit,
  input  logic              way1_dirty,
  input  logic              way1_valid,
  input  logic [31:0]       way0_addr_out,
  input  logic [31:0]       way1_addr_out,
  input  logic [31:0]       way0_data_out,
  input  logic [31:0]       way1_data_out,
  input  logic [LINE_W-1:0] way0_line_out,
  input  logic [LINE_W-1:0] way1_line_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wline,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rline,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT_RD,
    S_WB,
    S_REFILL,
    S_INSTALL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                retry_q, retry_d;
  logic                victim_q, victim_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]     lru_q, lru_d;

  logic [IDX_W-1:0]    set_idx;
  logic                h0, h1, any_hit, hit_way;
  logic                miss_victim, miss_victim_dirty;
  logic [31:0]         vic_addr_out;
  logic [LINE_W-1:0]   vic_line_out;
  logic                mem_done;

  assign set_idx = addr_q[5 +: IDX_W];

  // A raw tag match only counts together with valid. If both ways claim a
  // hit, way 0 wins.
  assign h0      = way0_hit & way0_valid;
  assign h1      = way1_hit & way1_valid & ~h0;
  assign any_hit = h0 | h1;
  assign hit_way = h1;

  // Fill an invalid way first (way 0 preferred), otherwise follow the LRU bit.
  assign miss_victim       = ~way0_valid ? 1'b0 : (~way1_valid ? 1'b1 : lru_q[set_idx]);
  assign miss_victim_dirty = miss_victim ? (way1_valid & way1_dirty)
                                         : (way0_valid & way0_dirty);

  assign vic_addr_out = victim_q ? way1_addr_out : way0_addr_out;
  assign vic_line_out = victim_q ? way1_line_out : way0_line_out;

  // Only an ack against an outstanding request counts.
  assign mem_done = mem_req_q & mem_ack;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    retry_d     = retry_q;
    victim_d    = victim_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lru_d       = lru_q;
    cpu_ready   = 1'b0;
    way_en      = 2'b00;
    way_compare = 1'b0;
    way_read    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          be_d    = cpu_be;
          retry_d = 1'b0;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        way_en      = 2'b11;
        way_compare = 1'b1;
        way_read    = ~we_q;
        if (any_hit) begin
          if (!retry_q) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end
          lru_d[set_idx] = ~hit_way;
          if (we_q) begin
            // Only the hitting way may take the byte-enabled write.
            way_en   = hit_way ? 2'b10 : 2'b01;
            way_read = 1'b0;
            rdata_d  = 32'h0;
          end else begin
            rdata_d = hit_way ? way1_data_out : way0_data_out;
          end
          state_d = S_DONE;
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          victim_d   = miss_victim;
          if (miss_victim_dirty) begin
            state_d = S_EVICT_RD;
          end else begin
            mem_addr_d = {addr_q[31:5], 5'b0};
            mem_we_d   = 1'b0;
            state_d    = S_REFILL;
          end
        end
      end

      S_EVICT_RD: begin
        // The way loads its line output at the negedge. Capture it here so
        // the writeback line and address stay stable for the whole request.
        way_en     = victim_q ? 2'b10 : 2'b01;
        way_read   = 1'b1;
        line_d     = vic_line_out;
        mem_addr_d = vic_addr_out & 32'hFFFF_FFE0;
        mem_we_d   = 1'b1;
        state_d    = S_WB;
      end

      S_WB: begin
        if (mem_done) begin
          mem_req_d  = 1'b0;
          mem_addr_d = {addr_q[31:5], 5'b0};
          mem_we_d   = 1'b0;
          state_d    = S_REFILL;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      S_REFILL: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          line_d    = mem_rline;
          state_d   = S_INSTALL;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      S_INSTALL: begin
        way_en         = victim_q ? 2'b10 : 2'b01;
        lru_d[set_idx] = ~victim_q;
        retry_d        = 1'b1;
        state_d        = S_LOOKUP;
      end

      S_DONE: begin
        cpu_ready = 1'b1;
        rdata_d   = 32'h0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      retry_q    <= 1'b0;
      victim_q   <= 1'b0;
      line_q     <= '0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      retry_q    <= retry_d;
      victim_q   <= victim_d;
      line_q     <= line_d;
      rdata_q    <= rdata_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      lru_q      <= lru_d;
    end
  end

  assign cpu_rdata   = rdata_q;
  assign cpu_busy    = (state_q != S_IDLE);
  assign way_addr    = addr_q;
  assign way_wdata   = wdata_q;
  assign way_be      = be_q;
  assign way_line_in = line_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wline   = line_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule
